lfsr_prbs_checker: RTL and testbench
====================================

# lfsr_prbs_checker

Serial PRBS checker that consumes the 10-bit Fibonacci LFSR bit stream (feedback polynomial tap pair 9/8, new bit = s[9] ^ s[8]) and reports synchronisation and bit errors. It sits directly downstream of the LFSR generator, either on-chip or across a loopback path. It self-synchronises from the received bits, then free-runs a local reference so that a single line error counts once and does not propagate. Outputs drive status pins and counters for bring-up and BER measurement.

## Interface
- WIDTH, 10: LFSR length; also the number of fill bits taken before checking starts.
- TAP_A, 9: first feedback tap index.
- TAP_B, 8: second feedback tap index.
- LOCK_COUNT, 16: consecutive correct predictions required to enter LOCKED; range 1..255.
- ERR_LIMIT, 4: consecutive mispredictions in LOCKED that force a return to HUNT; range 1..255.
- CNT_W, 16: width of both counters.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_bit is sampled this cycle.
- in_bit  in  1  received stream bit; equals the bit the generator shifts into its position 0 on each step.
- clear_cnt  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mispredicted bit while LOCKED.
- err_count  out  CNT_W  saturating count of mispredicted bits while LOCKED.
- bit_count  out  CNT_W  saturating count of valid bits checked while LOCKED.

## Operation
- Register sr[WIDTH-1:0], sr[0] newest. Prediction is p = sr[TAP_A] ^ sr[TAP_B]. On each valid bit, sr <= {sr[WIDTH-2:0], b}.
- Cycles with in_valid=0 leave all state and counters unchanged. err_pulse is 0 in those cycles.
- State HUNT (reset state):
  - b = in_bit.
  - fill counter counts to WIDTH and then holds.
  - Once fill = WIDTH, each valid bit is compared against p. A match with sr != 0 increments match_cnt. A mismatch, or any match with sr == 0, clears match_cnt. This prevents locking on an all-zero stream.
  - When match_cnt reaches LOCK_COUNT: go to LOCKED and clear miss_cnt.
- State LOCKED:
  - b = p, so the reference free-runs. It stays nonzero because the transition is invertible and zero is a fixed point.
  - Each valid bit increments bit_count.
  - in_bit != p asserts err_pulse, increments err_count and increments miss_cnt.
  - in_bit == p clears miss_cnt.
  - When miss_cnt reaches ERR_LIMIT: go to HUNT and clear fill and match_cnt. The counters keep their values.
- Counters saturate at 2^CNT_W-1. clear_cnt zeroes both and has priority over a simultaneous increment. clear_cnt does not affect state or sr.
- The bit that causes the HUNT-to-LOCKED transition is not counted in bit_count. The bit that causes the LOCKED-to-HUNT transition is counted, and its error is counted.

## Timing
- Reset values: locked=0, err_pulse=0, err_count=0, bit_count=0, sr=0, fill=0, match_cnt=0, miss_cnt=0, state HUNT.
- rst asserted mid-stream overrides all other inputs in that cycle.
- All outputs are registered and update on the clock edge that samples the valid bit.
  - locked rises in the cycle after the LOCK_COUNT-th qualifying match.
  - err_pulse is high for exactly the cycle after the offending bit is sampled.
- Minimum lock latency is WIDTH + LOCK_COUNT valid bits: 26 with the defaults.
- Loss of lock: locked falls in the cycle after the ERR_LIMIT-th consecutive error.
- Throughput: one bit per clock, no back-pressure.

## Test plan
- Clean lock: reset, then feed a generator seeded 10'b1 with in_valid=1 continuously. locked rises after valid bit 26. Over a further 1000 bits: err_count=0, bit_count=1000.
- Single error: once locked, invert one bit. err_pulse fires once, err_count=1, locked stays 1, and the following bits produce no further errors.
- Loss of lock: once locked, invert 4 consecutive bits. err_count=4 and locked falls after the 4th. Then send a clean stream: locked returns after another 26 bits.
- All-zero input: send 200 zero bits with in_valid=1. locked stays 0, counters stay 0.
- Gapped valid: toggle in_valid=1010… on a clean stream. Lock occurs after 26 valid bits (about 52 cycles). bit_count increments only on valid cycles.
- Clear and saturation: with CNT_W=4, force 20 errors while keeping lock via alternating good/bad bits. err_count holds at 15. Assert clear_cnt together with an error bit: err_count=0 next cycle.

Source files
------------

// File: rtl/lfsr_prbs_checker.sv
// Serial PRBS checker for a Fibonacci LFSR stream: self-synchronises in HUNT,
// then free-runs a local reference in LOCKED and counts bit errors.
module lfsr_prbs_checker #(
  parameter int WIDTH      = 10,
  parameter int TAP_A      = 9,
  parameter int TAP_B      = 8,
  parameter int LOCK_COUNT = 16,
  parameter int ERR_LIMIT  = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int                FILL_W    = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
  localparam logic [7:0]        LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0]        MISS_LAST = 8'(ERR_LIMIT - 1);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sr;
  logic [FILL_W-1:0] fill;
  logic [7:0]        match_cnt;
  logic [7:0]        miss_cnt;

  logic pred;
  logic mismatch;
  logic sr_nz;

  always_comb begin
    pred     = sr[TAP_A] ^ sr[TAP_B];
    mismatch = in_bit ^ pred;
    sr_nz    = |sr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      sr        <= '0;
      fill      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            sr <= {sr[WIDTH-2:0], in_bit};
            if (fill != FILL_FULL) begin
              fill <= fill + 1'b1;
            end else if (!mismatch && sr_nz) begin
              // The qualifying match that completes the run triggers lock and is not counted.
              if (match_cnt == LOCK_LAST) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            sr <= {sr[WIDTH-2:0], pred};
            if (bit_count != '1) bit_count <= bit_count + 1'b1;
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (miss_cnt == MISS_LAST) begin
                state     <= HUNT;
                locked    <= 1'b0;
                fill      <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 8'd1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= HUNT;
        endcase
      end
      // Later assignment wins, giving clear priority over any increment above.
      if (clear_cnt) begin
        err_count <= '0;
        bit_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: two instances (16-bit and 4-bit counters) on one
// stimulus stream, compared every cycle against a queue-based model.
module tb_lfsr_prbs_checker;

  localparam int LOCK_N = 16;
  localparam int ERR_N  = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_bit, clear_cnt;
  logic        locked16, pulse16, locked4, pulse4;
  logic [15:0] errc16, bitc16;
  logic [3:0]  errc4, bitc4;

  always #5 clk = ~clk;

  lfsr_prbs_checker #(.WIDTH(10), .TAP_A(9), .TAP_B(8), .LOCK_COUNT(LOCK_N),
                      .ERR_LIMIT(ERR_N), .CNT_W(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear_cnt(clear_cnt),
    .locked(locked16), .err_pulse(pulse16), .err_count(errc16), .bit_count(bitc16));

  lfsr_prbs_checker #(.WIDTH(10), .TAP_A(9), .TAP_B(8), .LOCK_COUNT(LOCK_N),
                      .ERR_LIMIT(ERR_N), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear_cnt(clear_cnt),
    .locked(locked4), .err_pulse(pulse4), .err_count(errc4), .bit_count(bitc4));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: hunt history as a bit queue, locked reference as a 10-bit integer LFSR.
  bit         hq[$];
  bit         m_lk, m_pulse;
  int         m_errs, m_bits, m_miss;
  logic [9:0] m_ref;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int trailing_run();
    int  n, run;
    bit  nz, ok;
    n   = hq.size();
    run = 0;
    for (int i = n - 1; i >= 10; i--) begin
      nz = 1'b0;
      for (int j = i - 10; j < i; j++) nz |= hq[j];
      ok = nz && (hq[i] == (hq[i-10] ^ hq[i-9]));
      if (!ok) break;
      run++;
    end
    return run;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic b, input logic c);
    logic p;
    if (r) begin
      m_lk = 0; m_pulse = 0; m_errs = 0; m_bits = 0; m_miss = 0;
      hq.delete();
      return;
    end
    m_pulse = 0;
    if (v) begin
      if (!m_lk) begin
        hq.push_back(b);
        if (trailing_run() == LOCK_N) begin
          m_lk   = 1;
          m_miss = 0;
          for (int k = 0; k < 10; k++) m_ref[k] = hq[hq.size()-1-k];
          hq.delete();
        end
      end else begin
        p     = m_ref[9] ^ m_ref[8];
        m_ref = {m_ref[8:0], p};
        m_bits++;
        if (b != p) begin
          m_pulse = 1;
          m_errs++;
          m_miss++;
          if (m_miss == ERR_N) begin
            m_lk   = 0;
            m_miss = 0;
            hq.delete();
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (c) begin
      m_errs = 0;
      m_bits = 0;
    end
  endtask

  always @(posedge clk) begin
    #2;
    check("locked16",    int'(locked16), int'(m_lk));
    check("locked4",     int'(locked4),  int'(m_lk));
    check("err_pulse16", int'(pulse16),  int'(m_pulse));
    check("err_pulse4",  int'(pulse4),   int'(m_pulse));
    check("err_count16", int'(errc16),   sat(m_errs, 16));
    check("err_count4",  int'(errc4),    sat(m_errs, 4));
    check("bit_count16", int'(bitc16),   sat(m_bits, 16));
    check("bit_count4",  int'(bitc4),    sat(m_bits, 4));
  end

  logic [9:0] g;

  task automatic gen(output logic b);
    b = g[9] ^ g[8];
    g = {g[8:0], b};
  endtask

  task automatic send(input logic r, input logic v, input logic b, input logic c);
    rst = r; in_valid = v; in_bit = b; clear_cnt = c;
    model_step(r, v, b, c);
    @(posedge clk);
    #4;
  endtask

  initial begin
    logic b;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_cnt = 1'b0;
    g = 10'd1;
    repeat (3) send(1, 0, 0, 0);
    check("reset_locked", int'(locked16), 0);
    check("reset_errc",   int'(errc16),   0);

    // clean lock from seed 1
    for (int i = 1; i <= 26; i++) begin
      gen(b); send(0, 1, b, 0);
      if (i == 25) check("pre_lock_25", int'(locked16), 0);
    end
    check("lock_at_26", int'(locked16), 1);
    check("lock_bits0", int'(bitc16), 0);
    repeat (1000) begin gen(b); send(0, 1, b, 0); end
    check("clean_bits1000", int'(bitc16), 1000);
    check("clean_err0",     int'(errc16), 0);
    check("clean_bits4sat", int'(bitc4),  15);

    // single inverted bit
    gen(b); send(0, 1, ~b, 0);
    check("single_pulse",  int'(pulse16),  1);
    check("single_locked", int'(locked16), 1);
    repeat (50) begin gen(b); send(0, 1, b, 0); end
    check("single_errc1", int'(errc16), 1);
    check("single_still", int'(locked16), 1);

    // loss of lock, then relock
    for (int i = 0; i < 4; i++) begin
      gen(b); send(0, 1, ~b, 0);
      if (i < 3) check("loss_hold", int'(locked16), 1);
    end
    check("loss_errc5",  int'(errc16),   5);
    check("loss_locked", int'(locked16), 0);
    for (int i = 1; i <= 26; i++) begin
      gen(b); send(0, 1, b, 0);
      if (i == 25) check("relock_pre", int'(locked16), 0);
    end
    check("relock_26", int'(locked16), 1);

    // reset mid-stream while locked, with a valid bit present
    gen(b); send(1, 1, b, 0);
    check("midrst_locked", int'(locked16), 0);
    check("midrst_errc",   int'(errc16),   0);
    check("midrst_bitc",   int'(bitc16),   0);

    // all-zero stream
    repeat (200) send(0, 1, 0, 0);
    check("zero_locked", int'(locked16), 0);
    check("zero_errc",   int'(errc16),   0);
    check("zero_bitc",   int'(bitc16),   0);

    // gapped valid, idle cycles carry junk bits
    send(1, 0, 0, 0);
    g = 10'd1;
    for (int cyc = 0; cyc <= 50; cyc++) begin
      if (cyc % 2 == 0) begin gen(b); send(0, 1, b, 0); end
      else send(0, 0, 1'($urandom % 2), 0);
      if (cyc == 49) check("gap_pre_lock", int'(locked16), 0);
    end
    check("gap_lock", int'(locked16), 1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc % 2 == 1) begin gen(b); send(0, 1, b, 0); end
      else send(0, 0, 1'($urandom % 2), 0);
    end
    check("gap_bits20", int'(bitc16), 20);

    // saturation via alternating bad/good bits
    for (int i = 0; i < 40; i++) begin
      gen(b);
      send(0, 1, (i % 2 == 0) ? ~b : b, 0);
    end
    check("sat_err4",    int'(errc4),    15);
    check("sat_err16",   int'(errc16),   20);
    check("sat_locked",  int'(locked16), 1);
    gen(b); send(0, 1, ~b, 1);
    check("clr_pulse",   int'(pulse16), 1);
    check("clr_err4",    int'(errc4),   0);
    check("clr_err16",   int'(errc16),  0);
    check("clr_bits16",  int'(bitc16),  0);
    repeat (5) begin gen(b); send(0, 1, b, 0); end
    check("post_clr_err",  int'(errc16), 0);
    check("post_clr_bits", int'(bitc16), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
